// File: rtl/tris_bus_ctrl_pkg.sv
// Shared types and constants for the tristate single-wire pad controller.
package tris_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      TURN  = 2'd2
   } state_e;

   localparam int   SYNC_STAGES = 2;
   localparam logic RESET_LEVEL = 1'b1;

   // Bits needed to hold values 0..max_val.
   function automatic int cnt_bits(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/tris_bus_ctrl_channel.sv
// One pad channel: start-pulse FSM, tristate control, input synchroniser,
// glitch filter with edge strobe, and level-width capture.
module tris_channel
   import tris_pkg::*;
#(
   parameter int FILT_CYC = 4,
   parameter int TURN_CYC = 2,
   parameter int PULSE_W  = 20,
   parameter int CNT_W    = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               dir_i,
   input  logic               send_i,
   input  logic               pulse_start_i,
   input  logic [PULSE_W-1:0] pulse_len_i,
   input  logic               pad_i,
   output logic               pad_oe_o,
   output logic               pad_val_o,
   output logic               read_o,
   output logic               busy_o,
   output logic               edge_o,
   output logic [CNT_W-1:0]   width_o
);

   localparam int                 FW        = cnt_bits(FILT_CYC);
   localparam logic [PULSE_W-1:0] TURN_LD   = PULSE_W'(TURN_CYC);
   localparam logic [FW-1:0]      FILT_LAST = FW'(FILT_CYC - 1);

   state_e               state_q;
   logic [PULSE_W-1:0]   cnt_q;
   logic                 busy_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pulse_start_i && (pulse_len_i != '0)) begin
                  state_q <= PULSE;
                  cnt_q   <= pulse_len_i;
                  busy_q  <= 1'b1;
               end
            end
            PULSE: begin
               if (cnt_q == PULSE_W'(1)) begin
                  if (TURN_CYC == 0) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= TURN;
                     cnt_q   <= TURN_LD;
                  end
               end else begin
                  cnt_q <= cnt_q - PULSE_W'(1);
               end
            end
            TURN: begin
               if (cnt_q == PULSE_W'(1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - PULSE_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Reset gates the enable directly so the pad lets go without waiting for a clock.
   assign pad_oe_o  = rst_ni & (((state_q == IDLE) & dir_i) | (state_q == PULSE));
   assign pad_val_o = (state_q != PULSE) & send_i;

   logic                   frozen;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic                   read_q, read_d;
   logic                   edge_q, edge_d;
   logic [CNT_W-1:0]       lvl_q, lvl_d;
   logic [CNT_W-1:0]       width_q, width_d;

   // Our own drive and the turnaround window must never look like sensor activity.
   assign frozen   = pad_oe_o | (state_q == TURN);
   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_comb begin
      fcnt_d  = fcnt_q;
      read_d  = read_q;
      edge_d  = 1'b0;
      width_d = width_q;
      lvl_d   = (&lvl_q) ? lvl_q : lvl_q + CNT_W'(1);
      if (frozen) begin
         fcnt_d = '0;
      end else if (sync_lvl != read_q) begin
         if (fcnt_q == FILT_LAST) begin
            read_d  = sync_lvl;
            fcnt_d  = '0;
            edge_d  = 1'b1;
            width_d = lvl_q;
            lvl_d   = CNT_W'(1);
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end else begin
         fcnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
         fcnt_q  <= '0;
         read_q  <= RESET_LEVEL;
         edge_q  <= 1'b0;
         lvl_q   <= '0;
         width_q <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
         fcnt_q  <= fcnt_d;
         read_q  <= read_d;
         edge_q  <= edge_d;
         lvl_q   <= lvl_d;
         width_q <= width_d;
      end
   end

   assign read_o  = read_q;
   assign busy_o  = busy_q;
   assign edge_o  = edge_q;
   assign width_o = width_q;

endmodule

// File: rtl/tris_bus_ctrl.sv
// N-channel bidirectional pad controller: one tris_channel per pad, pads
// driven here so the tristate buffers sit at the top of the slice.
module tris_bus_ctrl
   import tris_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int FILT_CYC = 4,
   parameter int TURN_CYC = 2,
   parameter int PULSE_W  = 20,
   parameter int CNT_W    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   inout  wire  [N_CH-1:0]       io_port,
   input  logic [N_CH-1:0]       i_dir,
   input  logic [N_CH-1:0]       i_send,
   input  logic [N_CH-1:0]       i_pulse_start,
   input  logic [PULSE_W-1:0]    i_pulse_len,
   output logic [N_CH-1:0]       o_read,
   output logic [N_CH-1:0]       o_busy,
   output logic [N_CH-1:0]       o_edge,
   output logic [N_CH*CNT_W-1:0] o_width
);

   logic [N_CH-1:0] pad_oe;
   logic [N_CH-1:0] pad_val;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      tris_channel #(
         .FILT_CYC (FILT_CYC),
         .TURN_CYC (TURN_CYC),
         .PULSE_W  (PULSE_W),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk_i         (i_clk),
         .rst_ni        (i_rst_n),
         .dir_i         (i_dir[k]),
         .send_i        (i_send[k]),
         .pulse_start_i (i_pulse_start[k]),
         .pulse_len_i   (i_pulse_len),
         .pad_i         (io_port[k]),
         .pad_oe_o      (pad_oe[k]),
         .pad_val_o     (pad_val[k]),
         .read_o        (o_read[k]),
         .busy_o        (o_busy[k]),
         .edge_o        (o_edge[k]),
         .width_o       (o_width[k*CNT_W +: CNT_W])
      );

      assign io_port[k] = pad_oe[k] ? pad_val[k] : 1'bz;
   end

endmodule
